writeback_unit: RTL and testbench
=================================

# writeback_unit

Writeback stage that drives the write port of the 32×32 register file. It merges single-cycle ALU results with multi-cycle load results, holding loads in a 2-entry buffer behind a valid/ready handshake. It sign- or zero-extends load data and produces the registered `write_reg` / `write_data` / `cs_reg_write` triple consumed by the register file.

## Interface
- `LOAD_DEPTH`, 2, load buffer entries (power of two, ≥2)
- `STARVE_LIMIT`, 3, cycles a buffered load may wait before `alu_stall` asserts
- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `alu_valid`  in  1  ALU result present this cycle
- `alu_rd`  in  5  ALU destination register
- `alu_result`  in  32  ALU result
- `alu_stall`  out  1  ALU producer must not present a result this cycle
- `load_valid`  in  1  load result offered
- `load_ready`  out  1  buffer can accept a load result
- `load_rd`  in  5  load destination register
- `load_data`  in  32  raw memory word
- `load_funct3`  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- `load_addr_lo`  in  2  byte offset of the load address
- `write_reg`  out  5  register-file write address
- `write_data`  out  32  register-file write data
- `cs_reg_write`  out  1  register-file write enable

## Operation
- **Load accept:** a load is accepted when `load_valid && load_ready`.
  - `load_ready` = buffer count < `LOAD_DEPTH`. It is combinational from state and independent of `load_valid` and of a same-cycle drain.
- **Extension at enqueue:**
  - LB/LBU select the byte at `load_addr_lo`.
  - LH/LHU select the halfword at `load_addr_lo[1]`.
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - LW and reserved funct3 codes pass the word unchanged.
- **Buffer:** FIFO of {rd, 32-bit data}.
  - A load with rd = 0 is accepted and discarded; it never occupies an entry.
- **Per-cycle selection**, in priority order:
  1. `alu_stall` high → drain the FIFO head; `alu_valid` is ignored.
  2. `alu_valid` with `alu_rd` ≠ 0 → write the ALU result.
  3. Otherwise, FIFO non-empty → drain the head.
  4. Otherwise, no write.
- **ALU writes to x0:** an ALU result with `alu_rd` = 0 is dropped, and that cycle is free for a drain.
- **Invariant:** `cs_reg_write` is never asserted with `write_reg` = 0.
- **Simultaneous accept and drain:** a same-cycle accept and drain keep the count unchanged and preserve FIFO order.
- **Age counter:** a 2-bit counter counts cycles during which the FIFO is non-empty and the head was not drained.
  - It clears on any drain and when the FIFO is empty.
  - `alu_stall` = (counter ≥ `STARVE_LIMIT`) && FIFO non-empty.

## Timing
- **Reset values:** all outputs 0 (`write_reg`, `write_data`, `cs_reg_write`, `alu_stall`). `load_ready` = 1 during and after reset. FIFO empty, age counter 0.
- **Latency:** a result selected in cycle N appears on the write port in cycle N+1 (registered outputs). The register file captures it at the end of N+1, and it is readable in N+2.
- **Load path:** a load accepted in cycle N can be drained no earlier than cycle N+1; the write port asserts no earlier than N+2.
- **Reset mid-operation:** asserting reset empties the buffer immediately. Buffered loads are lost and any in-flight write-port output is cleared asynchronously.
- **Stall timing:** `alu_stall` is combinational from registered state. It asserts in the cycle after the counter reaches `STARVE_LIMIT` and holds for exactly one cycle per starved drain.

## Configuration
- **`WB_STARVE_GUARD_EN` defined:** the age counter and `alu_stall` behave as above.
- **`WB_STARVE_GUARD_EN` undefined:**
  - No age counter; `alu_stall` is tied to 0.
  - Loads drain only in cycles with no ALU write.
  - A permanently busy ALU may block the load path indefinitely.

## Structure
- **Shared package `rv_pkg`:**
  - funct3 load constants (`F3_LB`, `F3_LH`, `F3_LW`, `F3_LBU`, `F3_LHU`)
  - `REG_ZERO` = 5'd0
  - `XLEN` = 32
  - `LOAD_DEPTH` default
- **Sub-module `load_align`:** combinational. Takes funct3, addr_lo and raw word; returns the extended 32-bit value. Instantiated once, at the enqueue point.
- FIFO pointers, count and age counter stay inline in `writeback_unit`.

## Test plan
- **ALU only:** `alu_valid` with rd=5, result 0xDEADBEEF in cycle 3 → `cs_reg_write`=1, `write_reg`=5, `write_data`=0xDEADBEEF in cycle 4; x5 reads 0xDEADBEEF from cycle 5.
- **Load extension:** data 0x80FF7F01 with LB/addr_lo 3 → 0xFFFFFF80; LBU/addr_lo 1 → 0x0000007F; LH/addr_lo 2 → 0xFFFF80FF; LHU/addr_lo 0 → 0x00007F01.
- **x0 suppression:** ALU rd=0 concurrent with one buffered load rd=7 → the load drains that cycle and `cs_reg_write` never asserts with `write_reg`=0. A load with rd=0 leaves count at 0.
- **Buffer full:** two loads accepted while `alu_valid` is held high with rd≠0 → `load_ready`=0; a third `load_valid` stays pending. Once drained, the loads retire in order.
- **Starvation (guard enabled):** FIFO holds one load, `alu_valid` continuously high → `alu_stall`=1 in the 4th cycle after enqueue and the load writes. Without the macro, `alu_stall` stays 0.
- **Async reset:** `reset` driven low mid-stream with 2 loads buffered → outputs 0 immediately, `load_ready`=1; no stale write after reset is released.

Source files
------------

// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared RISC-V constants and writeback selection type
package rv_pkg;

    localparam int XLEN               = 32;
    localparam int DEFAULT_LOAD_DEPTH = 2;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Source chosen for the register-file write port in a given cycle.
    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_ALU,
        SEL_LOAD
    } wb_sel_e;

endpackage

// File: rtl/writeback_unit_if.sv
// rtl/writeback_unit_if.sv - ALU/load inputs and register-file write port bundle
//   slave  : writeback unit view (consumes ALU/load results, drives write port)
//   master : producer/consumer view (drives ALU/load results, observes write port)
interface writeback_unit_if;
    import rv_pkg::*;

    logic            alu_valid;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_result;
    logic            alu_stall;

    logic            load_valid;
    logic            load_ready;
    logic [4:0]      load_rd;
    logic [XLEN-1:0] load_data;
    logic [2:0]      load_funct3;
    logic [1:0]      load_addr_lo;

    logic [4:0]      write_reg;
    logic [XLEN-1:0] write_data;
    logic            cs_reg_write;

    modport slave (
        input  alu_valid, alu_rd, alu_result,
        input  load_valid, load_rd, load_data, load_funct3, load_addr_lo,
        output alu_stall, load_ready,
        output write_reg, write_data, cs_reg_write
    );

    modport master (
        output alu_valid, alu_rd, alu_result,
        output load_valid, load_rd, load_data, load_funct3, load_addr_lo,
        input  alu_stall, load_ready,
        input  write_reg, write_data, cs_reg_write
    );
endinterface

// File: rtl/writeback_unit_load_align.sv
// rtl/writeback_unit_load_align.sv - load byte/halfword select and sign/zero extension
//   funct3_i  : load type
//   addr_lo_i : byte offset of the load address
//   word_i    : raw memory word
//   data_o    : extended result
module load_align
    import rv_pkg::*;
(
    input  logic [2:0]      funct3_i,
    input  logic [1:0]      addr_lo_i,
    input  logic [XLEN-1:0] word_i,
    output logic [XLEN-1:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo_i)
            2'd1:    byte_sel = word_i[15:8];
            2'd2:    byte_sel = word_i[23:16];
            2'd3:    byte_sel = word_i[31:24];
            default: byte_sel = word_i[7:0];
        endcase

        half_sel = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];

        case (funct3_i)
            F3_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  data_o = {24'd0, byte_sel};
            F3_LH:   data_o = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  data_o = {16'd0, half_sel};
            F3_LW:   data_o = word_i;
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/writeback_unit.sv
// rtl/writeback_unit.sv - register-file writeback merging ALU results and buffered loads
//   clk   : clock
//   reset : asynchronous active-low reset
//   wb    : writeback_unit_if.slave (ALU result, load handshake, write port, alu_stall)
//   Optional macro WB_STARVE_GUARD_EN: age counter forcing a load drain via alu_stall.
module writeback_unit
    import rv_pkg::*;
#(
    parameter int LOAD_DEPTH   = DEFAULT_LOAD_DEPTH,
    parameter int STARVE_LIMIT = 3
) (
    input  logic            clk,
    input  logic            reset,
    writeback_unit_if.slave wb
);

    localparam int PW = (LOAD_DEPTH > 1) ? $clog2(LOAD_DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [4:0]      rd_mem   [LOAD_DEPTH];
    logic [XLEN-1:0] data_mem [LOAD_DEPTH];

    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, count_d;
    logic [4:0]      write_reg_q, write_reg_d;
    logic [XLEN-1:0] write_data_q, write_data_d;
    logic            cs_q, cs_d;

    logic [XLEN-1:0] aligned;
    logic            fifo_nonempty;
    logic            load_ready;
    logic            enqueue;
    logic            drain;
    logic            stall;
    wb_sel_e         sel;

    load_align u_load_align (
        .funct3_i  (wb.load_funct3),
        .addr_lo_i (wb.load_addr_lo),
        .word_i    (wb.load_data),
        .data_o    (aligned)
    );

    assign fifo_nonempty = (count_q != '0);
    assign load_ready    = (count_q < CW'(LOAD_DEPTH));
    // Loads to x0 complete the handshake but are never stored.
    assign enqueue       = wb.load_valid && load_ready && (wb.load_rd != REG_ZERO);

`ifdef WB_STARVE_GUARD_EN
    localparam logic [1:0] STARVE_LIM = 2'(STARVE_LIMIT);

    logic [1:0] age_q, age_d;

    assign stall = (age_q >= STARVE_LIM) && fifo_nonempty;

    always_comb begin
        age_d = age_q;
        if (!fifo_nonempty || drain) begin
            age_d = 2'd0;
        end else if (age_q != 2'd3) begin
            age_d = age_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            age_q <= 2'd0;
        end else begin
            age_q <= age_d;
        end
    end
`else
    assign stall = 1'b0;
`endif

    always_comb begin
        sel          = SEL_NONE;
        cs_d         = 1'b0;
        write_reg_d  = REG_ZERO;
        write_data_d = '0;

        if (stall) begin
            sel = SEL_LOAD;
        end else if (wb.alu_valid && (wb.alu_rd != REG_ZERO)) begin
            sel = SEL_ALU;
        end else if (fifo_nonempty) begin
            sel = SEL_LOAD;
        end

        case (sel)
            SEL_ALU: begin
                cs_d         = 1'b1;
                write_reg_d  = wb.alu_rd;
                write_data_d = wb.alu_result;
            end
            SEL_LOAD: begin
                cs_d         = 1'b1;
                write_reg_d  = rd_mem[rd_ptr_q];
                write_data_d = data_mem[rd_ptr_q];
            end
            default: ;
        endcase
    end

    assign drain   = (sel == SEL_LOAD);
    assign count_d = count_q + CW'(enqueue) - CW'(drain);

    always_ff @(posedge clk) begin
        if (enqueue) begin
            rd_mem[wr_ptr_q]   <= wb.load_rd;
            data_mem[wr_ptr_q] <= aligned;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            cs_q         <= 1'b0;
            write_reg_q  <= REG_ZERO;
            write_data_q <= '0;
        end else begin
            if (enqueue) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (drain)   rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q      <= count_d;
            cs_q         <= cs_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
        end
    end

    assign wb.load_ready   = load_ready;
    assign wb.alu_stall    = stall;
    assign wb.cs_reg_write = cs_q;
    assign wb.write_reg    = write_reg_q;
    assign wb.write_data   = write_data_q;

endmodule

// File: tb/tb_writeback_unit.sv
// tb/tb_writeback_unit.sv - directed table-driven bench for writeback_unit
module tb_writeback_unit;
    import rv_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    writeback_unit_if wb ();

    writeback_unit #(
        .LOAD_DEPTH   (2),
        .STARVE_LIMIT (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .wb    (wb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file as the consumer of the write port.
    logic [31:0] regs [32];
    always @(posedge clk) begin
        if (wb.cs_reg_write) regs[wb.write_reg] <= wb.write_data;
    end

    // x0 must never be written.
    always @(negedge clk) begin
        if (wb.cs_reg_write) begin
            checks++;
            if (wb.write_reg == 5'd0) begin
                failures++;
                $display("FAIL x0_write actual write_reg=%0d required nonzero", wb.write_reg);
            end
        end
    end

    typedef struct {
        logic        is_load;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [2:0]  f3;
        logic [1:0]  lo;
        logic [31:0] exp;
        int          lat;
        string       name;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wb.alu_valid    = 1'b0;
        wb.alu_rd       = 5'd0;
        wb.alu_result   = 32'd0;
        wb.load_valid   = 1'b0;
        wb.load_rd      = 5'd0;
        wb.load_data    = 32'd0;
        wb.load_funct3  = F3_LW;
        wb.load_addr_lo = 2'd0;
    endtask

    task automatic set_load(input logic [4:0] rd, input logic [31:0] data,
                            input logic [2:0] f3, input logic [1:0] lo);
        wb.load_valid   = 1'b1;
        wb.load_rd      = rd;
        wb.load_data    = data;
        wb.load_funct3  = f3;
        wb.load_addr_lo = lo;
    endtask

    int          nrec;
    logic [4:0]  rec_rd   [8];
    logic [31:0] rec_data [8];
    logic        acc;

    initial begin
        checks   = 0;
        failures = 0;

        vecs[0] = '{1'b0, 5'd5,  32'hDEADBEEF, F3_LW,  2'd0, 32'hDEADBEEF, 1, "alu_rd5"};
        vecs[1] = '{1'b0, 5'd31, 32'h12345678, F3_LW,  2'd0, 32'h12345678, 1, "alu_rd31"};
        vecs[2] = '{1'b1, 5'd1,  32'h80FF7F01, F3_LB,  2'd3, 32'hFFFFFF80, 2, "lb_a3"};
        vecs[3] = '{1'b1, 5'd2,  32'h80FF7F01, F3_LBU, 2'd1, 32'h0000007F, 2, "lbu_a1"};
        vecs[4] = '{1'b1, 5'd3,  32'h80FF7F01, F3_LH,  2'd2, 32'hFFFF80FF, 2, "lh_a2"};
        vecs[5] = '{1'b1, 5'd4,  32'h80FF7F01, F3_LHU, 2'd0, 32'h00007F01, 2, "lhu_a0"};
        vecs[6] = '{1'b1, 5'd6,  32'h80FF7F01, F3_LW,  2'd1, 32'h80FF7F01, 2, "lw"};
        vecs[7] = '{1'b1, 5'd8,  32'h000000FF, F3_LB,  2'd0, 32'hFFFFFFFF, 2, "lb_a0_neg"};
        vecs[8] = '{1'b1, 5'd9,  32'hFFFF0000, F3_LHU, 2'd2, 32'h0000FFFF, 2, "lhu_a2"};
        vecs[9] = '{1'b1, 5'd12, 32'hCAFEF00D, 3'b011, 2'd2, 32'hCAFEF00D, 2, "reserved_f3"};

        // Reset state
        idle_inputs();
        reset = 1'b0;
        #1;
        chk("rst_cs",    32'(wb.cs_reg_write), 32'd0);
        chk("rst_reg",   32'(wb.write_reg),    32'd0);
        chk("rst_data",  wb.write_data,        32'd0);
        chk("rst_stall", 32'(wb.alu_stall),    32'd0);
        chk("rst_ready", 32'(wb.load_ready),   32'd1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        chk("post_rst_ready", 32'(wb.load_ready), 32'd1);
        step();

        // Table: single ALU results and single loads with extension
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].is_load) begin
                set_load(vecs[i].rd, vecs[i].data, vecs[i].f3, vecs[i].lo);
            end else begin
                wb.alu_valid  = 1'b1;
                wb.alu_rd     = vecs[i].rd;
                wb.alu_result = vecs[i].data;
            end
            for (int k = 1; k <= vecs[i].lat; k++) begin
                step();
                if (k == 1) idle_inputs();
                if (k < vecs[i].lat) begin
                    chk({vecs[i].name, "_early_cs"}, 32'(wb.cs_reg_write), 32'd0);
                end else begin
                    chk({vecs[i].name, "_cs"},   32'(wb.cs_reg_write), 32'd1);
                    chk({vecs[i].name, "_reg"},  32'(wb.write_reg),    32'(vecs[i].rd));
                    chk({vecs[i].name, "_data"}, wb.write_data,        vecs[i].exp);
                end
            end
            step();
            chk({vecs[i].name, "_done_cs"}, 32'(wb.cs_reg_write), 32'd0);
        end
        chk("regfile_x5", regs[5], 32'hDEADBEEF);

        // ALU to x0 frees the cycle for a buffered load
        set_load(5'd7, 32'h00000011, F3_LW, 2'd0);
        step();
        idle_inputs();
        wb.alu_valid  = 1'b1;
        wb.alu_rd     = 5'd0;
        wb.alu_result = 32'h00000BAD;
        step();
        idle_inputs();
        chk("x0alu_cs",   32'(wb.cs_reg_write), 32'd1);
        chk("x0alu_reg",  32'(wb.write_reg),    32'd7);
        chk("x0alu_data", wb.write_data,        32'h00000011);
        step();

        // Load to x0 is discarded
        set_load(5'd0, 32'h00000099, F3_LW, 2'd0);
        step();
        idle_inputs();
        step();
        chk("x0load_cs_a", 32'(wb.cs_reg_write), 32'd0);
        step();
        chk("x0load_cs_b", 32'(wb.cs_reg_write), 32'd0);
        wb.alu_valid  = 1'b1;
        wb.alu_rd     = 5'd10;
        wb.alu_result = 32'h0000A1A1;
        set_load(5'd9, 32'h00000009, F3_LW, 2'd0);
        step();
        wb.load_valid = 1'b0;
        chk("x0load_count_ready", 32'(wb.load_ready), 32'd1);
        wb.alu_valid = 1'b0;
        step();
        chk("x0load_next_reg", 32'(wb.write_reg), 32'd9);
        step();
        step();

        // Buffer full under a busy ALU, then in-order retirement
        wb.alu_valid  = 1'b1;
        wb.alu_rd     = 5'd10;
        wb.alu_result = 32'h0000A1A1;
        set_load(5'd11, 32'h0000000A, F3_LW, 2'd0);
        step();
        chk("full_ready_one", 32'(wb.load_ready), 32'd1);
        set_load(5'd12, 32'h0000000B, F3_LW, 2'd0);
        step();
        chk("full_ready_zero", 32'(wb.load_ready), 32'd0);
        set_load(5'd13, 32'h0000000C, F3_LW, 2'd0);
        step();
        chk("full_pending_ready", 32'(wb.load_ready), 32'd0);
        wb.alu_valid = 1'b0;
        nrec = 0;
        for (int s = 0; s < 8; s++) begin
            acc = wb.load_valid && wb.load_ready;
            step();
            if (acc) wb.load_valid = 1'b0;
            if (wb.cs_reg_write && wb.write_reg != 5'd10 && nrec < 8) begin
                rec_rd[nrec]   = wb.write_reg;
                rec_data[nrec] = wb.write_data;
                nrec++;
            end
        end
        chk("full_nrec", 32'(nrec), 32'd3);
        for (int r = 0; r < 3; r++) begin
            if (r < nrec) begin
                chk("full_order_rd",   32'(rec_rd[r]), 32'(11 + r));
                chk("full_order_data", rec_data[r],    32'(10 + r));
            end
        end
        idle_inputs();

        // Starvation of a single buffered load behind a busy ALU
        wb.alu_valid  = 1'b1;
        wb.alu_rd     = 5'd15;
        wb.alu_result = 32'h00005555;
        set_load(5'd14, 32'h0000CAFE, F3_LW, 2'd0);
        step();
        wb.load_valid = 1'b0;
        for (int j = 1; j <= 6; j++) begin
`ifdef WB_STARVE_GUARD_EN
            chk("starve_stall", 32'(wb.alu_stall), 32'(j == 4));
            if (j == 5) begin
                chk("starve_write_reg",  32'(wb.write_reg), 32'd14);
                chk("starve_write_data", wb.write_data,     32'h0000CAFE);
            end
`else
            chk("nostarve_stall", 32'(wb.alu_stall), 32'd0);
            if (j >= 2) chk("nostarve_alu_reg", 32'(wb.write_reg), 32'd15);
`endif
            step();
        end
        wb.alu_valid = 1'b0;
        step();
`ifndef WB_STARVE_GUARD_EN
        chk("nostarve_drain_reg",  32'(wb.write_reg), 32'd14);
        chk("nostarve_drain_data", wb.write_data,     32'h0000CAFE);
`endif
        step();
        idle_inputs();

        // Asynchronous reset with two loads buffered
        wb.alu_valid  = 1'b1;
        wb.alu_rd     = 5'd20;
        wb.alu_result = 32'h00002020;
        set_load(5'd21, 32'h00000021, F3_LW, 2'd0);
        step();
        set_load(5'd22, 32'h00000022, F3_LW, 2'd0);
        step();
        wb.load_valid = 1'b0;
        chk("arst_pre_ready", 32'(wb.load_ready),   32'd0);
        chk("arst_pre_cs",    32'(wb.cs_reg_write), 32'd1);
        #3;
        reset = 1'b0;
        #1;
        chk("arst_cs",    32'(wb.cs_reg_write), 32'd0);
        chk("arst_reg",   32'(wb.write_reg),    32'd0);
        chk("arst_data",  wb.write_data,        32'd0);
        chk("arst_ready", 32'(wb.load_ready),   32'd1);
        chk("arst_stall", 32'(wb.alu_stall),    32'd0);
        idle_inputs();
        step();
        reset = 1'b1;
        for (int s = 0; s < 4; s++) begin
            step();
            chk("arst_no_stale", 32'(wb.cs_reg_write), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
